// File: rtl/bsg_nor3_gather_pkg.sv
// Shared types for the 3-input NOR operand gatherer.
package bsg_nor3_gather_pkg;

    typedef enum logic [1:0] {
        eA    = 2'd0,
        eB    = 2'd1,
        eC    = 2'd2,
        eFull = 2'd3
    } gather_state_e;

endpackage

// File: rtl/bsg_nor3.sv
// Bitwise 3-input NOR stage fed by bsg_nor3_gather.
module bsg_nor3 #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic [width_p-1:0] c_i,
    output logic [width_p-1:0] o
);

    assign o = ~(a_i | b_i | c_i);

endmodule

// File: rtl/bsg_nor3_gather.sv
// Collects three operand words from a valid/ready stream into a registered
// {a,b,c} triplet held until yumied; counts consumed triplets.
module bsg_nor3_gather #(
    parameter int width_p       = 16,
    parameter int count_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    input  logic                     clear_i,
    output logic                     v_o,
    output logic [width_p-1:0]       a_o,
    output logic [width_p-1:0]       b_o,
    output logic [width_p-1:0]       c_o,
    input  logic                     yumi_i,
    output logic [count_width_p-1:0] count_o
);

    import bsg_nor3_gather_pkg::*;

    gather_state_e             state_r, state_n;
    logic [width_p-1:0]        a_r, b_r, c_r;
    logic [count_width_p-1:0]  count_r;
    logic                      accept;
    logic                      clear_ok;
    logic                      take;

    assign ready_o  = ~reset_i & (state_r != eFull);
    assign accept   = v_i & ready_o;
    assign clear_ok = clear_i & (state_r != eFull);
    // yumi outside eFull is illegal and deliberately has no effect
    assign take     = yumi_i & (state_r == eFull);

    always_comb begin
        state_n = state_r;
        if (clear_ok) begin
            state_n = eA;
        end else begin
            case (state_r)
                eA:      if (accept) state_n = eB;
                eB:      if (accept) state_n = eC;
                eC:      if (accept) state_n = eFull;
                eFull:   if (take)   state_n = eA;
                default: state_n = eA;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eA;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_n;
            if (clear_ok) begin
                a_r <= '0;
                b_r <= '0;
                c_r <= '0;
            end else if (accept) begin
                case (state_r)
                    eA:      a_r <= data_i;
                    eB:      b_r <= data_i;
                    eC:      c_r <= data_i;
                    default: ;
                endcase
            end
            if (take)
                count_r <= count_r + count_width_p'(1);
        end
    end

    assign v_o     = (state_r == eFull);
    assign a_o     = a_r;
    assign b_o     = b_r;
    assign c_o     = c_r;
    assign count_o = count_r;

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_nor3_gather.sv
// Directed and randomized-backpressure checks of bsg_nor3_gather feeding bsg_nor3.
module tb_bsg_nor3_gather;

    logic        clk = 1'b0;
    logic        reset_i, v_i, clear_i, yumi_i;
    logic [15:0] data_i;
    logic        ready_o, v_o;
    logic [15:0] a_o, b_o, c_o, nor_o;
    logic [7:0]  count_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bsg_nor3_gather #(.width_p(16), .count_width_p(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .clear_i(clear_i), .v_o(v_o),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .yumi_i(yumi_i), .count_o(count_o)
    );

    bsg_nor3 #(.width_p(16)) nor_stage (
        .a_i(a_o), .b_i(b_o), .c_i(c_o), .o(nor_o)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        clr;
        logic        yumi;
        logic        ev;
        logic        er;
        logic [15:0] ea, eb, ec;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic v, logic [15:0] d, logic clr, logic yumi,
                                logic ev, logic er, logic [15:0] ea, logic [15:0] eb,
                                logic [15:0] ec, logic [7:0] ecnt);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.yumi = yumi;
        r.ev = ev; r.er = er; r.ea = ea; r.eb = eb; r.ec = ec; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard state for the randomized run
    logic [47:0] sb_q[$];
    int          m_state;
    logic [15:0] m_a, m_b, m_c;
    logic [7:0]  m_cnt;
    int          done_trip;
    int          cycles;
    logic        saw_wrap;

    initial begin
        reset_i = 1'b1; v_i = 1'b0; clear_i = 1'b0; yumi_i = 1'b0; data_i = '0;

        // reset phase
        #1;
        chk("ready_in_reset0", {31'd0, ready_o}, 32'd0);
        tick();
        chk("ready_in_reset1", {31'd0, ready_o}, 32'd0);
        chk("reset_v", {31'd0, v_o}, 32'd0);
        chk("reset_a", {16'd0, a_o}, 32'd0);
        chk("reset_b", {16'd0, b_o}, 32'd0);
        chk("reset_c", {16'd0, c_o}, 32'd0);
        chk("reset_cnt", {24'd0, count_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, ready_o}, 32'd1);

        //          v  data     clr  yumi ev  er  a        b        c        cnt
        tbl[0]  = mk(1, 16'h00F0, 0, 0, 0, 1, 16'h00F0, 16'h0000, 16'h0000, 8'd0);
        tbl[1]  = mk(1, 16'h0F00, 0, 0, 0, 1, 16'h00F0, 16'h0F00, 16'h0000, 8'd0);
        tbl[2]  = mk(1, 16'hF000, 0, 0, 1, 0, 16'h00F0, 16'h0F00, 16'hF000, 8'd0);
        tbl[3]  = mk(0, 16'h0000, 0, 1, 0, 1, 16'h00F0, 16'h0F00, 16'hF000, 8'd1);
        tbl[4]  = mk(1, 16'h1234, 0, 0, 0, 1, 16'h1234, 16'h0F00, 16'hF000, 8'd1);
        tbl[5]  = mk(1, 16'h5678, 0, 0, 0, 1, 16'h1234, 16'h5678, 16'hF000, 8'd1);
        tbl[6]  = mk(1, 16'h9999, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'd1);
        tbl[7]  = mk(1, 16'h0001, 0, 0, 0, 1, 16'h0001, 16'h0000, 16'h0000, 8'd1);
        tbl[8]  = mk(1, 16'h0002, 0, 0, 0, 1, 16'h0001, 16'h0002, 16'h0000, 8'd1);
        tbl[9]  = mk(1, 16'h0004, 0, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[10] = mk(1, 16'hFFFF, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[11] = mk(1, 16'hFFFF, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[12] = mk(1, 16'hFFFF, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[13] = mk(1, 16'hFFFF, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[14] = mk(1, 16'hFFFF, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0004, 8'd1);
        tbl[15] = mk(0, 16'h0000, 0, 1, 0, 1, 16'h0001, 16'h0002, 16'h0004, 8'd2);
        tbl[16] = mk(0, 16'hBEEF, 0, 0, 0, 1, 16'h0001, 16'h0002, 16'h0004, 8'd2);
        tbl[17] = mk(0, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 8'd2);

        for (int i = 0; i < 18; i++) begin
            v_i = tbl[i].v; data_i = tbl[i].d; clear_i = tbl[i].clr; yumi_i = tbl[i].yumi;
            tick();
            v_i = 1'b0; clear_i = 1'b0; yumi_i = 1'b0;
            chk($sformatf("vec%0d_v", i),     {31'd0, v_o},     {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].er});
            chk($sformatf("vec%0d_a", i),     {16'd0, a_o},     {16'd0, tbl[i].ea});
            chk($sformatf("vec%0d_b", i),     {16'd0, b_o},     {16'd0, tbl[i].eb});
            chk($sformatf("vec%0d_c", i),     {16'd0, c_o},     {16'd0, tbl[i].ec});
            chk($sformatf("vec%0d_cnt", i),   {24'd0, count_o}, {24'd0, tbl[i].ecnt});
            if (i == 2 || i == 9)
                chk($sformatf("vec%0d_nor", i), {16'd0, nor_o},
                    {16'd0, ~(tbl[i].ea | tbl[i].eb | tbl[i].ec)});
        end
        chk("nor_000F_literal", {16'd0, ~(16'h00F0 | 16'h0F00 | 16'hF000)}, 32'h000F);

        // randomized backpressure: 256 triplets, count wraps through zero
        m_state = 0; m_a = '0; m_b = '0; m_c = '0; m_cnt = 8'd2;
        done_trip = 0; cycles = 0; saw_wrap = 1'b0;
        while (done_trip < 256 && cycles < 20000) begin
            chk("rnd_ready", {31'd0, ready_o}, {31'd0, (m_state != 3)});
            chk("rnd_v",     {31'd0, v_o},     {31'd0, (m_state == 3)});
            chk("rnd_cnt",   {24'd0, count_o}, {24'd0, m_cnt});
            v_i     = ($urandom_range(0, 3) != 0);
            data_i  = 16'($urandom);
            yumi_i  = (m_state == 3) && ($urandom_range(0, 1) == 1);
            clear_i = 1'b0;
            if (yumi_i) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("rnd_triplet_a", {16'd0, a_o}, {16'd0, sb_q[0][47:32]});
                    chk("rnd_triplet_b", {16'd0, b_o}, {16'd0, sb_q[0][31:16]});
                    chk("rnd_triplet_c", {16'd0, c_o}, {16'd0, sb_q[0][15:0]});
                    chk("rnd_nor", {16'd0, nor_o},
                        {16'd0, ~(sb_q[0][47:32] | sb_q[0][31:16] | sb_q[0][15:0])});
                    void'(sb_q.pop_front());
                end
                m_cnt = m_cnt + 8'd1;
                if (m_cnt == 8'd0) saw_wrap = 1'b1;
                m_state = 0;
                done_trip++;
            end else if (v_i && m_state != 3) begin
                case (m_state)
                    0: m_a = data_i;
                    1: m_b = data_i;
                    default: begin
                        m_c = data_i;
                        sb_q.push_back({m_a, m_b, m_c});
                    end
                endcase
                m_state++;
            end
            tick();
            cycles++;
        end
        v_i = 1'b0; yumi_i = 1'b0;
        if (done_trip < 256)
            chk("rnd_timeout", done_trip, 256);
        chk("rnd_wrap_seen", {31'd0, saw_wrap}, 32'd1);
        chk("rnd_final_cnt", {24'd0, count_o}, {24'd0, 8'd2});

        // reset while in eC with a partial triplet
        v_i = 1'b1; data_i = 16'hAAAA; tick();
        data_i = 16'hBBBB; tick();
        v_i = 1'b0;
        chk("partial_a", {16'd0, a_o}, 32'h0000AAAA);
        chk("partial_ready", {31'd0, ready_o}, 32'd1);
        reset_i = 1'b1; v_i = 1'b1; data_i = 16'hCCCC;
        #1;
        chk("midreset_ready", {31'd0, ready_o}, 32'd0);
        tick();
        reset_i = 1'b0; v_i = 1'b0;
        chk("midreset_v", {31'd0, v_o}, 32'd0);
        chk("midreset_a", {16'd0, a_o}, 32'd0);
        chk("midreset_b", {16'd0, b_o}, 32'd0);
        chk("midreset_c", {16'd0, c_o}, 32'd0);
        chk("midreset_cnt", {24'd0, count_o}, 32'd0);
        #1;
        chk("midreset_ready_after", {31'd0, ready_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
